// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if
//   Bundles the writeback requester bus, the register-file write port and the
//   issue-side scoreboard query signals of rf_write_arbiter.
//   master : requesters / issue logic (drive requests and queries)
//   slave  : the arbiter (grants, drives RF write port, answers queries)
//   Requester i occupies req_waddr[i*AW +: AW] and req_wdata[i*XLEN +: XLEN].
interface rf_write_arbiter_if #(
  parameter int NR_REQ = 3,
  parameter int XLEN   = 32,
  parameter int AW     = 5
);
  logic [NR_REQ-1:0]      req_valid;
  logic [NR_REQ*AW-1:0]   req_waddr;
  logic [NR_REQ*XLEN-1:0] req_wdata;
  logic [NR_REQ-1:0]      req_ready;
  logic                   rf_we;
  logic [AW-1:0]          rf_waddr;
  logic [XLEN-1:0]        rf_wdata;
  logic                   issue_valid;
  logic [AW-1:0]          issue_rd;
  logic [AW-1:0]          rs1_addr;
  logic [AW-1:0]          rs2_addr;
  logic                   rs1_busy;
  logic                   rs2_busy;
  logic                   init_done;

  modport master (
    output req_valid, req_waddr, req_wdata, issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  req_ready, rf_we, rf_waddr, rf_wdata, rs1_busy, rs2_busy, init_done
  );

  modport slave (
    input  req_valid, req_waddr, req_wdata, issue_valid, issue_rd, rs1_addr, rs2_addr,
    output req_ready, rf_we, rf_waddr, rf_wdata, rs1_busy, rs2_busy, init_done
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Owns the single register-file write port. After reset it sweeps every
//   register to zero (one per cycle), then shares the port between NR_REQ
//   writeback requesters with round-robin arbitration. A pending-write
//   scoreboard tells issue logic whether rs1/rs2 still await writeback.
// Ports
//   clk, rst : clock and synchronous active-high reset
//   bus      : rf_write_arbiter_if.slave -- requester valid/ready/waddr/wdata,
//              RF write port (rf_we/rf_waddr/rf_wdata), issue_valid/issue_rd,
//              rs1/rs2 query addresses and busy flags, init_done.
module rf_write_arbiter #(
  parameter int NR_REQ = 3,
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  localparam int AW    = $clog2(NREG),
  localparam int PW    = $clog2(NR_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  rf_write_arbiter_if.slave bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              init_done_q, init_done_d;

  logic              run_act;
  logic              grant_any;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     cand;
  logic [AW-1:0]     sel_waddr;
  logic [XLEN-1:0]   sel_wdata;
  logic              xfer;

  // Outputs are gated by rst so nothing is granted or written while reset is held,
  // even on the very first reset cycle before the state register has settled.
  assign run_act = !rst && (state_q == ST_RUN);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NR_REQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NR_REQ);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_waddr = bus.req_waddr[i*AW +: AW];
        sel_wdata = bus.req_wdata[i*XLEN +: XLEN];
      end
    end
  end

  assign xfer = run_act && grant_any;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ptr_d          = ptr_q;
    busy_d         = busy_q;
    init_done_d    = init_done_q;
    bus.req_ready  = '0;
    bus.rf_we      = 1'b0;
    bus.rf_waddr   = '0;
    bus.rf_wdata   = '0;

    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          bus.rf_we    = 1'b1;
          bus.rf_waddr = cnt_q;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == AW'(NREG - 1)) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (grant_any) begin
            bus.req_ready[grant_idx] = 1'b1;
            // Writes to x0 are consumed but never reach the register file.
            bus.rf_we    = (sel_waddr != '0);
            bus.rf_waddr = sel_waddr;
            bus.rf_wdata = sel_wdata;
            ptr_d        = grant_idx;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end

    // Clear before set so a same-cycle issue to the register being written
    // leaves it busy: the newly issued writer is still outstanding.
    if (xfer) busy_d[sel_waddr] = 1'b0;
    if (run_act && bus.issue_valid) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= PW'(NR_REQ - 1);
      busy_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.rs1_busy  = busy_q[bus.rs1_addr];
  assign bus.rs2_busy  = busy_q[bus.rs2_addr];
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int NR  = 3;
  localparam int XL  = 32;
  localparam int AWT = 5;

  localparam logic [31:0] DA = 32'hAAAA_0001;
  localparam logic [31:0] DB = 32'hBBBB_0002;
  localparam logic [31:0] DC = 32'hCCCC_0003;

  logic clk = 1'b0;
  logic rst;

  rf_write_arbiter_if #(.NR_REQ(NR), .XLEN(XL), .AW(AWT)) bus ();

  rf_write_arbiter #(.NR_REQ(NR), .XLEN(XL), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT write port; preloaded with garbage so the
  // zero sweep is observable.
  logic [31:0] rf_m [32];
  bit          rf_loaded = 1'b0;
  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) rf_m[i] <= 32'hBAD0_0000 | i;
      rf_loaded <= 1'b1;
    end else if (bus.rf_we) begin
      rf_m[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  typedef struct {
    logic [2:0]  ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    bit          dchk;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] v,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    bus.req_valid = v;
    bus.req_waddr = {a2, a1, a0};
    bus.req_wdata = {d2, d1, d0};
  endtask

  // Push the expected write-port/grant outcome for the inputs just driven,
  // then pop it against what the DUT presents this cycle.
  task automatic cycle_exp(input string tag, input logic [2:0] r, input logic we,
                           input logic [4:0] a, input logic [31:0] d, input bit dchk);
    exp_t e;
    sbq.push_back('{ready: r, we: we, waddr: a, wdata: d, dchk: dchk});
    #1;
    if (sbq.size() == 0) begin
      chk({tag, "_sbq_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'(e.ready));
      chk({tag, "_we"},    32'(bus.rf_we),     32'(e.we));
      chk({tag, "_waddr"}, 32'(bus.rf_waddr),  32'(e.waddr));
      if (e.dchk) chk({tag, "_wdata"}, bus.rf_wdata, e.wdata);
    end
  endtask

  initial begin
    logic [31:0] dv [3];
    int          nz;
    dv[0] = DA; dv[1] = DB; dv[2] = DC;

    rst             = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1_addr    = '0;
    bus.rs2_addr    = '0;
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    #1;

    // T1: two reset cycles, then the zero sweep
    cycle_exp("t1_rst0", 3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
    cyc();
    set_req(3'b111, 5'd1, 5'd2, 5'd3, DA, DB, DC);
    cycle_exp("t1_rst1", 3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t1_rst_init_done", 32'(bus.init_done), 32'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cycle_exp($sformatf("t1_sweep%0d", i), 3'b000, 1'b1, 5'(i), 32'd0, 1'b1);
      if (i == 0 || i == 31) chk("t1_init_done_low", 32'(bus.init_done), 32'd0);
      cyc();
    end

    // T2: round robin with all three requesters valid
    for (int j = 0; j < 6; j++) begin
      cycle_exp($sformatf("t2_rr%0d", j), 3'(1 << (j % 3)), 1'b1, 5'((j % 3) + 1), dv[j % 3], 1'b1);
      if (j == 0) begin
        chk("t1_init_done_high", 32'(bus.init_done), 32'd1);
        nz = 0;
        for (int r = 0; r < 32; r++) if (rf_m[r] != 32'd0) nz++;
        chk("t1_rf_all_zero", 32'(nz), 32'd0);
      end
      cyc();
    end

    // T3: write to x0 is consumed but discarded, and still moves the pointer
    set_req(3'b001, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    cycle_exp("t3_x0", 3'b001, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("t2_rf_x1", rf_m[1], DA);
    chk("t2_rf_x3", rf_m[3], DC);
    cyc();
    set_req(3'b011, 5'd4, 5'd6, 5'd0, 32'h40, 32'h60, 32'd0);
    cycle_exp("t3_ptr_adv", 3'b010, 1'b1, 5'd6, 32'h60, 1'b1);
    chk("t3_rf_x0", rf_m[0], 32'd0);
    cyc();

    // T4: scoreboard set / clear / set-wins / independent set+clear
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd0;
    cycle_exp("t4_issue", 3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t4_busy_nobypass", 32'(bus.rs1_busy), 32'd0);
    cyc();
    bus.issue_valid = 1'b0;
    cycle_exp("t4_idle", 3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t4_busy_set", 32'(bus.rs1_busy), 32'd1);
    chk("t4_x0_never_busy", 32'(bus.rs2_busy), 32'd0);
    cyc();
    set_req(3'b010, 5'd0, 5'd5, 5'd0, 32'd0, 32'h55, 32'd0);
    cycle_exp("t4_wb", 3'b010, 1'b1, 5'd5, 32'h55, 1'b1);
    chk("t4_busy_during_wb", 32'(bus.rs1_busy), 32'd1);
    cyc();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    cycle_exp("t4_idle2", 3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t4_busy_clr", 32'(bus.rs1_busy), 32'd0);
    cyc();
    bus.issue_valid = 1'b1;
    cycle_exp("t4_reissue", 3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
    cyc();
    set_req(3'b010, 5'd0, 5'd5, 5'd0, 32'd0, 32'h56, 32'd0);
    cycle_exp("t4_setclr", 3'b010, 1'b1, 5'd5, 32'h56, 1'b1);
    cyc();
    bus.issue_valid = 1'b0;
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    cycle_exp("t4_idle3", 3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t4_set_wins", 32'(bus.rs1_busy), 32'd1);
    cyc();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs2_addr = 5'd7;
    set_req(3'b010, 5'd0, 5'd5, 5'd0, 32'd0, 32'h57, 32'd0);
    cycle_exp("t4_diff", 3'b010, 1'b1, 5'd5, 32'h57, 1'b1);
    cyc();
    bus.issue_valid = 1'b0;
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    cycle_exp("t4_idle4", 3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t4_diff_clr", 32'(bus.rs1_busy), 32'd0);
    chk("t4_diff_set", 32'(bus.rs2_busy), 32'd1);
    cyc();

    // T5: reset during active traffic with busy bits set
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd9;
    set_req(3'b111, 5'd1, 5'd2, 5'd3, DA, DB, DC);
    rst = 1'b1;
    cycle_exp("t5_rst", 3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cycle_exp($sformatf("t5_sweep%0d", i), 3'b000, 1'b1, 5'(i), 32'd0, 1'b1);
      if (i == 0) begin
        chk("t5_sb_clr_x7", 32'(bus.rs1_busy), 32'd0);
        chk("t5_sb_clr_x9", 32'(bus.rs2_busy), 32'd0);
        chk("t5_init_done_low", 32'(bus.init_done), 32'd0);
      end
      cyc();
    end
    bus.issue_valid = 1'b0;
    cycle_exp("t5_run", 3'b001, 1'b1, 5'd1, DA, 1'b1);
    chk("t5_issue_ignored_init", 32'(bus.rs2_busy), 32'd0);
    chk("t5_init_done_high", 32'(bus.init_done), 32'd1);
    cyc();

    // T6: sparse requests and idle cycles
    set_req(3'b100, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 32'h0000_00C2);
    cycle_exp("t6_req2", 3'b100, 1'b1, 5'd10, 32'h0000_00C2, 1'b1);
    cyc();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    cycle_exp("t6_idle", 3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
    cyc();
    set_req(3'b001, 5'd11, 5'd0, 5'd0, 32'h0000_00C0, 32'd0, 32'd0);
    cycle_exp("t6_req0", 3'b001, 1'b1, 5'd11, 32'h0000_00C0, 1'b1);
    cyc();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    cycle_exp("t6_idle2", 3'b000, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t6_rf_x10", rf_m[10], 32'h0000_00C2);
    chk("t6_rf_x11", rf_m[11], 32'h0000_00C0);
    chk("t5_rf_x1", rf_m[1], DA);
    chk("t5_rf_x5_swept", rf_m[5], 32'd0);
    cyc();

    chk("sbq_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
